pcileech_mux_n: RTL
===================

Name: pcileech_mux_n

Overview:
Parametrised successor of the FT601 4-port word mux. Merges 32-bit words from NUM_PORTS requesters into 256-bit frames: one status word plus seven data words, each tagged with a 4-bit nibble (port id, ctx). Sits between the PCIe/config/loopback word sources and the FT601 TX FIFO. Adds:
- port-count and timeout parametrisation
- output almost-full backpressure
- collision reporting
- optional round-robin arbitration

Parameters:
NUM_PORTS, 4, number of input ports (1..4; port id is 2 bits)
SKIP_TIMEOUT, 8, idle cycles within a partial frame before filler words are inserted (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
din  in  32*NUM_PORTS  word for port i at [32i+31:32i]
ctx  in  2*NUM_PORTS  context for port i at [2i+1:2i]
wr_en  in  NUM_PORTS  port i presents a word this cycle
has_data  in  NUM_PORTS  port i has words pending
req_data  out  NUM_PORTS  registered one-hot grant to port i
out_afull  in  1  downstream FIFO almost full
dout  out  256  frame
valid  out  1  dout valid, single-cycle pulse
err_collision  out  1  one-cycle pulse: more than one wr_en seen in the same cycle

Behaviour:
- Reset (rst=0, async): valid=0, req_data=0, err_collision=0, dout=0; frame count=0, skip counter=0, data shift register=0, status nibbles all 4'hF.
- Grant: each cycle req_data <= one-hot of the highest-priority asserted has_data bit (port 0 highest), or 0 if out_afull=1 or no has_data. One-cycle registered latency.
- Accept: lowest-index asserted wr_en wins. Word shifts into the data register (newest at the low end); nibble {ctx[1:0], port[1:0]} shifts into the status register. Words are accepted regardless of out_afull, so in-flight words are never lost.
- Collision: if more than one wr_en is asserted, the losing words are dropped and err_collision=1 on the next cycle.
- Count: 0..6. An accepted or filler word at count<6 increments it. At count==6 the word completes the frame: count<=0, skip<=0, internal frame-valid set.
- Skip counter: increments each cycle with count>0 and no write. It is not cleared by writes, only at frame completion.
- Filler: while skip>=SKIP_TIMEOUT and no wr_en, a filler (nibble F, data FFFFFFFF) is inserted every cycle until the frame completes.
- Output: valid asserts 2 cycles after the cycle the 7th word is presented. dout is registered from the shift registers.
- Data layout: dout[31:0] = newest word (w0); dout[223:192] = oldest word (w6).
- Status word dout[255:224], with n0 newest and n6 oldest:
  - byte0 = {4'hE, n0}
  - byte1 = {n1, n2}
  - byte2 = {n3, n4}
  - byte3 = {n5, n6}
- Simultaneous frame completion and a new write is impossible (a single word per cycle completes the frame). The next frame starts from count 0 on the following cycle.
- out_afull thresholds must leave at least one frame of margin, because fillers complete partial frames under backpressure.
- Reset mid-frame discards the partial frame; no valid is emitted.

Optional Feature:
PCILEECH_MUX_ROUND_ROBIN_EN.
- Defined: a priority pointer rr_ptr (reset 0) selects the highest-priority port; priority then runs rr_ptr+1, … mod NUM_PORTS. At each frame completion, rr_ptr <= (port of the last non-filler word + 1) mod NUM_PORTS. Accept/collision resolution stays lowest-index.
- Undefined: fixed priority, port 0 highest.

Decomposition:
Package pcileech_mux_pkg:
- FRAME_WORDS=7
- FRAME_MAGIC=4'hE
- FILLER_NIBBLE=4'hF
- FILLER_WORD=32'hFFFFFFFF
- typedef mux_nibble_t {ctx[1:0], port[1:0]}
- function packing status nibbles into the status word

Sub-module pcileech_mux_arbiter: has_data, out_afull, rr_ptr → registered req_data; contains the round-robin logic under the macro.

Test Plan:
- Reset: 3 words from port 1, then rst=0 for 2 cycles, then 7 words from port 2 ctx=0 → exactly one valid; all nibbles 2; status word 0x222222E2.
- Full frame: port 0, ctx=2, words 0..6 on consecutive cycles → valid exactly 2 cycles after word 6; dout[31:0]=6, dout[223:192]=0; status 0x888888E8.
- Priority/collision: has_data=0101 → req_data=0001; drop bit0 → 0100 the next cycle. wr_en=0011 with din0=A, din1=B → A stored, err_collision pulse next cycle.
- Timeout: port 3 ctx 0 sends 2 words then idles, SKIP_TIMEOUT=8 → fillers after 8 idle cycles; valid with status 0x33FFFFEF, dout[159:0] all F, dout[223:160] = port 3 words.
- Backpressure: has_data=0001, out_afull=1 → req_data=0 from the next cycle; wr_en arriving one cycle after assertion is still accepted.
- Round robin (macro defined): all ports continuously have data → successive frames are sourced by ports 0,1,2,3,0. Macro undefined → all frames from port 0.

Source files
------------

// File: rtl/pcileech_mux_pkg.sv
// pcileech_mux_pkg: frame constants, tag nibble type and status-word packing shared by pcileech_mux_n.
package pcileech_mux_pkg;

    localparam int          FRAME_WORDS   = 7;
    localparam logic [3:0]  FRAME_MAGIC   = 4'hE;
    localparam logic [3:0]  FILLER_NIBBLE = 4'hF;
    localparam logic [31:0] FILLER_WORD   = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [1:0] ctx;
        logic [1:0] port;
    } mux_nibble_t;

    // nibbles[3:0] tags the newest word (n0), nibbles[27:24] the oldest (n6)
    function automatic logic [31:0] pack_status(input logic [4*FRAME_WORDS-1:0] nibbles);
        return {nibbles[23:20], nibbles[27:24],
                nibbles[15:12], nibbles[19:16],
                nibbles[7:4],   nibbles[11:8],
                FRAME_MAGIC,    nibbles[3:0]};
    endfunction

endpackage

// File: rtl/pcileech_mux_n_if.sv
// pcileech_mux_n_if: requester-side word bus and frame output bus of pcileech_mux_n.
interface pcileech_mux_n_if #(
    parameter int NUM_PORTS = 4
);

    logic [32*NUM_PORTS-1:0] din;
    logic [2*NUM_PORTS-1:0]  ctx;
    logic [NUM_PORTS-1:0]    wr_en;
    logic [NUM_PORTS-1:0]    has_data;
    logic [NUM_PORTS-1:0]    req_data;
    logic                    out_afull;
    logic [255:0]            dout;
    logic                    valid;
    logic                    err_collision;

    modport slave (
        input  din, ctx, wr_en, has_data, out_afull,
        output req_data, dout, valid, err_collision
    );

    modport master (
        output din, ctx, wr_en, has_data, out_afull,
        input  req_data, dout, valid, err_collision
    );

endinterface

// File: rtl/pcileech_mux_arbiter.sv
// pcileech_mux_arbiter: registered one-hot grant over has_data, suppressed while the output is almost full.
// PCILEECH_MUX_ROUND_ROBIN_EN starts the priority scan at rr_ptr instead of port 0.
module pcileech_mux_arbiter
    import pcileech_mux_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] has_data_i,
    input  logic                 out_afull_i,
`ifdef PCILEECH_MUX_ROUND_ROBIN_EN
    input  logic [1:0]           rr_ptr_i,
`endif
    output logic [NUM_PORTS-1:0] req_data_o
);

    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] req_data_d;
    logic [NUM_PORTS-1:0] req_data_q;

`ifdef PCILEECH_MUX_ROUND_ROBIN_EN
    // scan from the far end so the port nearest rr_ptr overrides
    always_comb begin
        pick = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (has_data_i[(int'(rr_ptr_i) + k) % NUM_PORTS]) begin
                pick = '0;
                pick[(int'(rr_ptr_i) + k) % NUM_PORTS] = 1'b1;
            end
    end
`else
    assign pick = has_data_i & (~has_data_i + NUM_PORTS'(1));
`endif

    assign req_data_d = out_afull_i ? '0 : pick;
    assign req_data_o = req_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            req_data_q <= '0;
        else
            req_data_q <= req_data_d;
    end

endmodule

// File: rtl/pcileech_mux_n.sv
// pcileech_mux_n: packs 32-bit words from NUM_PORTS requesters into 256-bit status+data frames for the FT601.
// Define PCILEECH_MUX_ROUND_ROBIN_EN to rotate grant priority after every completed frame.
module pcileech_mux_n
    import pcileech_mux_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int SKIP_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pcileech_mux_n_if.slave bus
);

    localparam int DW = 32 * FRAME_WORDS;
    localparam int SW = 4 * FRAME_WORDS;

    logic [DW-1:0] data_q, data_d;
    logic [SW-1:0] stat_q, stat_d;
    logic [2:0]    count_q, count_d;
    logic [3:0]    skip_q, skip_d;
    logic          frame_q;
    logic          valid_q;
    logic          coll_q;
    logic [255:0]  dout_q;
    logic [1:0]    sel;
    logic          acc;
    logic          filler;
    logic          push;
    logic          done;
    logic [31:0]   word;
    mux_nibble_t   nib;

    always_comb begin
        sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (bus.wr_en[i]) sel = 2'(i);
    end

    // fillers only pad a started frame once the requesters have gone quiet long enough
    assign acc    = |bus.wr_en;
    assign filler = !acc && count_q != 3'd0 && skip_q >= 4'(SKIP_TIMEOUT);
    assign push   = acc || filler;
    assign done   = push && count_q == 3'(FRAME_WORDS - 1);
    assign word   = acc ? bus.din[32*sel +: 32] : FILLER_WORD;
    assign nib    = acc ? mux_nibble_t'({bus.ctx[2*sel +: 2], sel}) : mux_nibble_t'(FILLER_NIBBLE);

    always_comb begin
        data_d  = push ? {data_q[DW-33:0], word} : data_q;
        stat_d  = push ? {stat_q[SW-5:0], nib} : stat_q;
        count_d = done ? 3'd0 : push ? count_q + 3'd1 : count_q;
        skip_d  = done ? 4'd0 : (count_q != 3'd0 && !push) ? skip_q + 4'd1 : skip_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            stat_q  <= '1;
            count_q <= '0;
            skip_q  <= '0;
            frame_q <= 1'b0;
            valid_q <= 1'b0;
            coll_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            data_q  <= data_d;
            stat_q  <= stat_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            frame_q <= done;
            valid_q <= frame_q;
            coll_q  <= |(bus.wr_en & (bus.wr_en - NUM_PORTS'(1)));
            if (frame_q) dout_q <= {pack_status(stat_q), data_q};
        end
    end

`ifdef PCILEECH_MUX_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] last_port_q;
    logic [1:0] src_port;

    // fillers carry no port, so the last real word decides who goes to the back
    assign src_port = acc ? sel : last_port_q;
    assign rr_ptr_d = !done ? rr_ptr_q :
                      (int'(src_port) == NUM_PORTS - 1) ? 2'd0 : src_port + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            last_port_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            last_port_q <= src_port;
        end
    end
`endif

    pcileech_mux_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .has_data_i (bus.has_data),
        .out_afull_i(bus.out_afull),
`ifdef PCILEECH_MUX_ROUND_ROBIN_EN
        .rr_ptr_i   (rr_ptr_q),
`endif
        .req_data_o (bus.req_data)
    );

    assign bus.dout          = dout_q;
    assign bus.valid         = valid_q;
    assign bus.err_collision = coll_q;

endmodule
